// File: rtl/mc6809_bus_initiator_pkg.sv
// Shared types and constants for the 6809-style bus initiator.
package mc6809_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] DEAD_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {
        Q0      = 3'd0,
        Q1      = 3'd1,
        Q2      = 3'd2,
        Q3      = 3'd3,
        STRETCH = 3'd4
    } phase_e;

    function automatic logic phase_e_high(phase_e p);
        return (p == Q2) || (p == Q3) || (p == STRETCH);
    endfunction

    function automatic logic phase_q_high(phase_e p);
        return (p == Q1) || (p == Q2);
    endfunction

endpackage

// File: rtl/mc6809_bus_initiator_if.sv
// Request side and bus-pin side of the initiator, grouped for port hookup.
interface mc6809_bus_initiator_if;
    import mc6809_bus_pkg::*;

    logic              i_req;
    logic              i_req_rw;
    logic [ADDR_W-1:0] i_req_addr;
    logic [DATA_W-1:0] i_req_wdata;
    logic              o_req_ready;
    logic              o_rsp_valid;
    logic [DATA_W-1:0] o_rsp_rdata;
    logic              o_rsp_err;
    logic              o_E;
    logic              o_Q;
    logic [ADDR_W-1:0] o_ADDRESS_BUS;
    logic              o_RW;
    logic [DATA_W-1:0] o_DATA_OUT;
    logic              o_DATA_OE;
    logic [DATA_W-1:0] i_DATA_IN;
    logic              i_MRDY;

    modport master (
        input  i_req, i_req_rw, i_req_addr, i_req_wdata, i_DATA_IN, i_MRDY,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
               o_E, o_Q, o_ADDRESS_BUS, o_RW, o_DATA_OUT, o_DATA_OE
    );

    modport slave (
        output i_req, i_req_rw, i_req_addr, i_req_wdata, i_DATA_IN, i_MRDY,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
               o_E, o_Q, o_ADDRESS_BUS, o_RW, o_DATA_OUT, o_DATA_OE
    );

endinterface

// File: rtl/mc6809_bus_initiator_eq_phase_gen.sv
// E/Q quadrature phase generator with MRDY stretch and timeout.
//   state   | meaning
//   Q0      | E=0 Q=0, address settles
//   Q1      | E=0 Q=1, write data driven
//   Q2      | E=1 Q=1
//   Q3      | E=1 Q=0, MRDY sampled on last clk
//   STRETCH | E=1 Q=0, extra quarter while responder holds MRDY low
module eq_phase_gen
    import mc6809_bus_pkg::*;
#(
    parameter int CLKS_PER_QUARTER = 4,
    parameter int MAX_STRETCH      = 40
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_mrdy,
    output phase_e o_phase_nxt,
    output logic   o_boundary,
    output logic   o_timeout,
    output logic   o_e,
    output logic   o_q
);
    localparam int QC_W = $clog2(CLKS_PER_QUARTER);
    localparam int SC_W = $clog2(MAX_STRETCH + 1);

    logic [QC_W-1:0] qc_q, qc_d;
    logic [SC_W-1:0] sc_q, sc_d;
    phase_e          phase_q, phase_d;
    logic            e_q, q_q;
    logic            last_clk;

    assign last_clk = (qc_q == QC_W'(CLKS_PER_QUARTER - 1));

    always_comb begin
        qc_d       = last_clk ? '0 : qc_q + QC_W'(1);
        phase_d    = phase_q;
        sc_d       = sc_q;
        o_boundary = 1'b0;
        o_timeout  = 1'b0;
        if (last_clk) begin
            case (phase_q)
                Q0: phase_d = Q1;
                Q1: phase_d = Q2;
                Q2: phase_d = Q3;
                Q3: begin
                    if (i_mrdy) begin
                        phase_d    = Q0;
                        o_boundary = 1'b1;
                    end else begin
                        phase_d = STRETCH;
                        sc_d    = sc_q + SC_W'(1);
                    end
                end
                STRETCH: begin
                    // Timeout forces the end even with MRDY still low
                    if (i_mrdy || (sc_q == SC_W'(MAX_STRETCH))) begin
                        phase_d    = Q0;
                        o_boundary = 1'b1;
                        o_timeout  = ~i_mrdy;
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
                default: phase_d = Q0;
            endcase
        end
        if (phase_d == Q0) sc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qc_q    <= '0;
            sc_q    <= '0;
            phase_q <= Q0;
            e_q     <= 1'b0;
            q_q     <= 1'b0;
        end else begin
            qc_q    <= qc_d;
            sc_q    <= sc_d;
            phase_q <= phase_d;
            e_q     <= phase_e_high(phase_d);
            q_q     <= phase_q_high(phase_d);
        end
    end

    assign o_phase_nxt = phase_d;
    assign o_e         = e_q;
    assign o_q         = q_q;

endmodule

// File: rtl/mc6809_bus_initiator.sv
// 6809-style bus initiator: request latch, bus drive and response around the E/Q generator.
module mc6809_bus_initiator
    import mc6809_bus_pkg::*;
#(
    parameter int CLKS_PER_QUARTER = 4,
    parameter int MAX_STRETCH      = 40
) (
    input logic                  clk,
    input logic                  i_RESET,
    mc6809_bus_initiator_if.master bus
);
    phase_e phase_nxt;
    logic   boundary, timeout, e_clk, q_clk, accept;

    eq_phase_gen #(
        .CLKS_PER_QUARTER (CLKS_PER_QUARTER),
        .MAX_STRETCH      (MAX_STRETCH)
    ) u_eq_phase_gen (
        .clk         (clk),
        .rst_n       (i_RESET),
        .i_mrdy      (bus.i_MRDY),
        .o_phase_nxt (phase_nxt),
        .o_boundary  (boundary),
        .o_timeout   (timeout),
        .o_e         (e_clk),
        .o_q         (q_clk)
    );

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d, rdata_q, rdata_d;
    logic              rw_q, rw_d, active_q, active_d, oe_q, oe_d;
    logic              rsp_valid_q, rsp_valid_d, err_q, err_d;

    assign accept = bus.i_req & boundary;

    always_comb begin
        addr_d      = addr_q;
        rw_d        = rw_q;
        dout_d      = dout_q;
        active_d    = active_q;
        rsp_valid_d = boundary & active_q;
        rdata_d     = (boundary & active_q & rw_q) ? bus.i_DATA_IN : '0;
        err_d       = boundary & active_q & timeout;
        // Without acceptance the next cycle is a dead cycle
        if (boundary) begin
            active_d = accept;
            rw_d     = accept ? bus.i_req_rw : 1'b1;
            addr_d   = accept ? bus.i_req_addr : DEAD_ADDR;
            dout_d   = (accept && !bus.i_req_rw) ? bus.i_req_wdata : '0;
        end
        oe_d = active_d & ~rw_d & (phase_nxt != Q0);
    end

    always_ff @(posedge clk or negedge i_RESET) begin
        if (!i_RESET) begin
            addr_q      <= DEAD_ADDR;
            rw_q        <= 1'b1;
            dout_q      <= '0;
            active_q    <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            dout_q      <= dout_d;
            active_q    <= active_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_req_ready   = accept;
    assign bus.o_rsp_valid   = rsp_valid_q;
    assign bus.o_rsp_rdata   = rdata_q;
    assign bus.o_rsp_err     = err_q;
    assign bus.o_E           = e_clk;
    assign bus.o_Q           = q_clk;
    assign bus.o_ADDRESS_BUS = addr_q;
    assign bus.o_RW          = rw_q;
    assign bus.o_DATA_OUT    = dout_q;
    assign bus.o_DATA_OE     = oe_q;

endmodule
